// File: rtl/tx_packet_parser.sv
// tx_packet_parser: parses 256-word USB TX packets and steers payload into per-channel TX FIFOs.
// Define TX_CTRL_CHAN_EN to route channel 5'h1f to the ctrl_* ports instead of discarding it.
module tx_packet_parser #(
  parameter int NUM_CHAN   = 2,
  parameter int MAXPAYLOAD = 504
) (
  input  logic                txclk,
  input  logic                reset_n,
  input  logic                usb_pkt_rdy,
  input  logic [15:0]         usb_data,
  output logic                usb_rdreq,
  input  logic [NUM_CHAN-1:0] chan_full,
  output logic [4:0]          chan_select,
  output logic                chan_wrreq,
  output logic [15:0]         chan_wrdata,
  output logic                chan_sob,
  output logic                chan_eob,
  output logic [31:0]         pkt_timestamp,
  output logic                pkt_ts_valid,
  output logic [15:0]         dropped_count,
  output logic [7:0]          debugbus
`ifdef TX_CTRL_CHAN_EN
  ,
  output logic                ctrl_wrreq,
  output logic [15:0]         ctrl_wrdata,
  input  logic                ctrl_full
`endif
);
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, TS_LO, TS_HI, PAYLOAD, DISCARD} state_t;
  state_t      state;
  logic [8:0]  payload_len;
  logic [8:0]  payload_words;
  logic [7:0]  word_cnt;
  logic        sob_flag;
  logic        eob_flag;
  logic [15:0] ts_lo;
  logic [31:0] full_vec;
  logic        sel_full;
  logic        is_ctrl;
  logic        in_data;
  logic        pkt_ok;
  logic        write;
  assign payload_words = 9'((10'(payload_len) + 10'd1) >> 1);
  assign full_vec      = 32'(chan_full);
`ifdef TX_CTRL_CHAN_EN
  assign is_ctrl  = chan_select == 5'h1f;
  assign sel_full = is_ctrl ? ctrl_full : full_vec[chan_select];
`else
  assign is_ctrl  = 1'b0;
  assign sel_full = full_vec[chan_select];
`endif
  assign in_data   = {1'b0, word_cnt} < payload_words;
  assign pkt_ok    = (int'(chan_select) < NUM_CHAN || is_ctrl) && int'(payload_len) <= MAXPAYLOAD;
  // once the payload is written, the pad words drain regardless of backpressure
  assign usb_rdreq = (state == IDLE) ? 1'b0 : (state == PAYLOAD && in_data) ? !sel_full : 1'b1;
  assign write     = state == PAYLOAD && in_data && !sel_full;
  assign debugbus  = {usb_pkt_rdy, usb_rdreq, chan_wrreq, |chan_full, 1'b0, state};
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      payload_len   <= '0;
      word_cnt      <= '0;
      sob_flag      <= 1'b0;
      eob_flag      <= 1'b0;
      ts_lo         <= '0;
      chan_select   <= '0;
      chan_wrreq    <= 1'b0;
      chan_wrdata   <= '0;
      chan_sob      <= 1'b0;
      chan_eob      <= 1'b0;
      pkt_timestamp <= '0;
      pkt_ts_valid  <= 1'b0;
      dropped_count <= '0;
`ifdef TX_CTRL_CHAN_EN
      ctrl_wrreq    <= 1'b0;
      ctrl_wrdata   <= '0;
`endif
    end else begin
      pkt_ts_valid <= 1'b0;
      chan_wrreq   <= write && !is_ctrl;
      chan_sob     <= write && !is_ctrl && sob_flag && word_cnt == 8'd0;
      chan_eob     <= write && !is_ctrl && eob_flag && {1'b0, word_cnt} == payload_words - 9'd1;
      if (write && !is_ctrl) chan_wrdata <= usb_data;
`ifdef TX_CTRL_CHAN_EN
      ctrl_wrreq <= write && is_ctrl;
      if (write && is_ctrl) ctrl_wrdata <= usb_data;
`endif
      case (state)
        IDLE: if (usb_pkt_rdy) state <= HDR1;
        HDR1: begin
          payload_len <= usb_data[8:0];
          word_cnt    <= '0;
          state       <= HDR2;
        end
        HDR2: begin
          chan_select <= usb_data[4:0];
          sob_flag    <= usb_data[12];
          eob_flag    <= usb_data[11];
          state       <= TS_LO;
        end
        TS_LO: begin
          ts_lo <= usb_data;
          state <= TS_HI;
        end
        TS_HI: begin
          pkt_timestamp <= {usb_data, ts_lo};
          pkt_ts_valid  <= 1'b1;
          state         <= pkt_ok ? PAYLOAD : DISCARD;
          if (!pkt_ok && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
        end
        PAYLOAD, DISCARD: if (usb_rdreq) begin
          word_cnt <= word_cnt + 8'd1;
          if (word_cnt == 8'd251) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_packet_parser.sv
// tb_tx_packet_parser: table-driven packet vectors plus stall, mid-packet reset and back-to-back sequences.
module tb_tx_packet_parser;
  logic        txclk = 1'b0;
  logic        reset_n;
  logic        usb_pkt_rdy;
  logic [15:0] usb_data;
  logic        usb_rdreq;
  logic [1:0]  chan_full;
  logic [4:0]  chan_select;
  logic        chan_wrreq;
  logic [15:0] chan_wrdata;
  logic        chan_sob;
  logic        chan_eob;
  logic [31:0] pkt_timestamp;
  logic        pkt_ts_valid;
  logic [15:0] dropped_count;
  logic [7:0]  debugbus;

  tx_packet_parser dut (
    .txclk(txclk), .reset_n(reset_n), .usb_pkt_rdy(usb_pkt_rdy), .usb_data(usb_data),
    .usb_rdreq(usb_rdreq), .chan_full(chan_full), .chan_select(chan_select),
    .chan_wrreq(chan_wrreq), .chan_wrdata(chan_wrdata), .chan_sob(chan_sob), .chan_eob(chan_eob),
    .pkt_timestamp(pkt_timestamp), .pkt_ts_valid(pkt_ts_valid), .dropped_count(dropped_count),
    .debugbus(debugbus)
  );

  always #5 txclk = ~txclk;

  typedef struct {
    logic [4:0]  chan;
    logic [8:0]  len;
    logic        sob;
    logic        eob;
    logic [31:0] ts;
    int          full_at;
    int          exp_wr;
    int          exp_drop;
  } vec_t;

  vec_t        v[8];
  logic [15:0] q[$];
  logic [15:0] wq[$];
  int          pop_cyc[$];
  int pops, cyc, nw, sob_cnt, sob_pos, eob_cnt, eob_pos, ts_pulses;
  int full_left, stall_at, stall_pops, full_cycles;
  int passed, total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] pword(input int id, input int k);
    return 16'((id + 1) << 12) ^ 16'(k * 7);
  endfunction

  task automatic refresh();
    usb_data    = q.size() > 0 ? q[0] : 16'h0;
    usb_pkt_rdy = q.size() >= 256;
  endtask

  // model of the show-ahead upstream FIFO plus capture of the channel write port
  task automatic tick();
    logic pop;
    @(negedge txclk);
    pop = usb_rdreq;
    if (chan_wrreq) begin
      if (chan_sob) begin sob_cnt++; sob_pos = nw; end
      if (chan_eob) begin eob_cnt++; eob_pos = nw; end
      wq.push_back(chan_wrdata);
      nw++;
    end
    if (pkt_ts_valid) ts_pulses++;
    if (chan_full[0]) begin
      full_cycles++;
      if (usb_rdreq) stall_pops++;
    end
    @(posedge txclk);
    #1;
    cyc++;
    if (pop) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (q.size() > 0) q.delete(0);
    end
    if (stall_at >= 0 && nw == stall_at) begin
      full_left = 20;
      stall_at  = -1;
    end
    chan_full = full_left > 0 ? 2'b01 : 2'b00;
    if (full_left > 0) full_left--;
    refresh();
  endtask

  task automatic clear_obs();
    wq.delete();
    pop_cyc.delete();
    nw = 0; pops = 0; sob_cnt = 0; eob_cnt = 0; sob_pos = -1; eob_pos = -1;
    ts_pulses = 0; stall_pops = 0; full_cycles = 0;
  endtask

  task automatic push_pkt(input vec_t t, input int id);
    q.push_back({3'b101, 4'hA, t.len});
    q.push_back({3'b010, t.sob, t.eob, 6'h2A, t.chan});
    q.push_back(t.ts[15:0]);
    q.push_back(t.ts[31:16]);
    for (int k = 0; k < 252; k++) q.push_back(pword(id, k));
    refresh();
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pops < target && n < 4000) begin
      tick();
      n++;
    end
    chk({name, " timeout"}, 32'(n < 4000), 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_pkt(input vec_t t, input int id, input string name);
    int bad = 0;
    int exp_s = (t.sob && t.exp_wr > 0) ? 1 : 0;
    int exp_e = (t.eob && t.exp_wr > 0) ? 1 : 0;
    chk({name, " pops"}, pops, 256);
    chk({name, " writes"}, nw, t.exp_wr);
    for (int i = 0; i < nw && i < t.exp_wr; i++) if (wq[i] !== pword(id, i)) bad++;
    chk({name, " data"}, bad, 0);
    chk({name, " sob count"}, sob_cnt, exp_s);
    if (exp_s == 1) chk({name, " sob pos"}, sob_pos, 0);
    chk({name, " eob count"}, eob_cnt, exp_e);
    if (exp_e == 1) chk({name, " eob pos"}, eob_pos, t.exp_wr - 1);
    chk({name, " timestamp"}, pkt_timestamp, t.ts);
    chk({name, " ts pulses"}, ts_pulses, 1);
    chk({name, " dropped"}, dropped_count, t.exp_drop);
    chk({name, " chan_select"}, chan_select, t.chan);
    chk({name, " idle"}, debugbus[2:0], 0);
  endtask

  initial begin
    int n;
    int bad;
    passed = 0; total = 0; cyc = 0; full_left = 0; stall_at = -1;
    reset_n = 1'b0; usb_pkt_rdy = 1'b0; usb_data = '0; chan_full = '0;
    clear_obs();
    v[0] = '{5'd0,  9'd504, 1'b1, 1'b1, 32'h12345678, -1,  252, 0};
    v[1] = '{5'd1,  9'd10,  1'b1, 1'b0, 32'h0000ABCD, -1,  5,   0};
    v[2] = '{5'd0,  9'd7,   1'b0, 1'b1, 32'hDEAD0001, -1,  4,   0};
    v[3] = '{5'd0,  9'd0,   1'b1, 1'b1, 32'h87654321, -1,  0,   0};
    v[4] = '{5'd3,  9'd20,  1'b1, 1'b1, 32'h00C0FFEE, -1,  0,   1};
    v[5] = '{5'd0,  9'd505, 1'b1, 1'b1, 32'hA5A5A5A5, -1,  0,   2};
    v[6] = '{5'd31, 9'd8,   1'b1, 1'b1, 32'h11112222, -1,  0,   3};
    v[7] = '{5'd0,  9'd504, 1'b1, 1'b1, 32'hCAFEF00D, 100, 252, 3};
    #2;
    chk("rst rdreq", usb_rdreq, 0);
    chk("rst wrreq", chan_wrreq, 0);
    chk("rst timestamp", pkt_timestamp, 0);
    chk("rst dropped", dropped_count, 0);
    chk("rst state", debugbus[2:0], 0);
    repeat (2) @(posedge txclk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clear_obs();
      stall_at = v[i].full_at;
      push_pkt(v[i], i);
      wait_pops(256, $sformatf("vec%0d", i));
      check_pkt(v[i], i, $sformatf("vec%0d", i));
      if (v[i].full_at >= 0) begin
        chk("stall cycles", full_cycles, 20);
        chk("stall pops", stall_pops, 0);
      end
    end
    // reset in the middle of a payload
    clear_obs();
    push_pkt(v[0], 8);
    n = 0;
    while (nw < 50 && n < 2000) begin
      tick();
      n++;
    end
    chk("midrst reached", 32'(n < 2000), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst rdreq", usb_rdreq, 0);
    chk("midrst wrreq", chan_wrreq, 0);
    chk("midrst wrdata", chan_wrdata, 0);
    chk("midrst timestamp", pkt_timestamp, 0);
    chk("midrst dropped", dropped_count, 0);
    chk("midrst state", debugbus[2:0], 0);
    q.delete();
    refresh();
    chan_full = '0;
    #10 reset_n = 1'b1;
    clear_obs();
    push_pkt(v[1], 9);
    wait_pops(256, "postrst");
    check_pkt(v[1], 9, "postrst");
    // two packets queued back to back
    clear_obs();
    push_pkt(v[1], 10);
    push_pkt(v[2], 11);
    wait_pops(512, "b2b");
    chk("b2b pops", pops, 512);
    chk("b2b writes", nw, 9);
    bad = 0;
    for (int i = 0; i < nw && i < 9; i++)
      if (wq[i] !== (i < 5 ? pword(10, i) : pword(11, i - 5))) bad++;
    chk("b2b data", bad, 0);
    if (pop_cyc.size() >= 257) chk("b2b gap", pop_cyc[256] - pop_cyc[255], 2);
    else chk("b2b gap pops", pop_cyc.size(), 512);
    chk("b2b timestamp", pkt_timestamp, v[2].ts);
    chk("b2b ts pulses", ts_pulses, 2);
    chk("b2b sob", sob_cnt, 1);
    chk("b2b eob pos", eob_pos, 8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
